// File: rtl/ex_mem_stage.sv
// EX + EX/MEM + MEM slice: 64-bit ALU, EX/MEM pipeline register, 256x64 dual-port data memory.
// Latency: ALU combinational, EX/MEM 1 cycle, memory read 1 more cycle; no stall, no backpressure.
module ex_mem_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ex_r1,
  input  logic [DATA_W-1:0] ex_r2,
  input  logic [3:0]        ex_opcode,
  input  logic              ex_wreg_en,
  input  logic              ex_wmem_en,
  input  logic [REG_W-1:0]  ex_wreg,
  output logic [DATA_W-1:0] ex_z,
  output logic              ex_carry,
  output logic              ex_overflow,
  output logic              mem_wreg_en,
  output logic              mem_wmem_en,
  output logic [REG_W-1:0]  mem_wreg,
  output logic [DATA_W-1:0] mem_z,
  output logic [DATA_W-1:0] mem_r1,
  output logic [DATA_W-1:0] mem_r2,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_din,
  input  logic              sw_we,
  output logic [DATA_W-1:0] sw_dout
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_SRA  = 4'b1101
  } alu_op_e;

  typedef struct packed {
    logic              wreg_en;
    logic              wmem_en;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] z;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
  } exmem_t;

  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic [SH_W-1:0]   sh;

  // SUB shares the adder as A + ~B + 1, so carry-out means "no borrow".
  assign is_sub = (ex_opcode == OP_SUB);
  assign b_eff  = is_sub ? ~ex_r2 : ex_r2;
  assign sum    = {1'b0, ex_r1} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
  assign sh     = ex_r2[SH_W-1:0];

  always_comb begin
    ex_z        = '0;
    ex_carry    = 1'b0;
    ex_overflow = 1'b0;
    case (ex_opcode)
      OP_ADD, OP_SUB: begin
        ex_z        = sum[DATA_W-1:0];
        ex_carry    = sum[DATA_W];
        ex_overflow = (ex_r1[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (sum[DATA_W-1] != ex_r1[DATA_W-1]);
      end
      OP_SLL:  ex_z = ex_r1 << sh;
      OP_SLT:  ex_z = {{(DATA_W-1){1'b0}}, ($signed(ex_r1) < $signed(ex_r2))};
      OP_SLTU: ex_z = {{(DATA_W-1){1'b0}}, (ex_r1 < ex_r2)};
      OP_XOR:  ex_z = ex_r1 ^ ex_r2;
      OP_SRL:  ex_z = ex_r1 >> sh;
      OP_SRA:  ex_z = $unsigned($signed(ex_r1) >>> sh);
      OP_OR:   ex_z = ex_r1 | ex_r2;
      OP_AND:  ex_z = ex_r1 & ex_r2;
      default: ex_z = '0;
    endcase
  end

  exmem_t ex_d;
  exmem_t mem_q;

  assign ex_d = {ex_wreg_en, ex_wmem_en, ex_wreg, ex_z, ex_r1, ex_r2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= ex_d;
  end

  assign mem_wreg_en = mem_q.wreg_en;
  assign mem_wmem_en = mem_q.wmem_en;
  assign mem_wreg    = mem_q.wreg;
  assign mem_z       = mem_q.z;
  assign mem_r1      = mem_q.r1;
  assign mem_r2      = mem_q.r2;

  logic [DATA_W-1:0] dmem [DEPTH];
  logic [ADDR_W-1:0] addr_a;

  assign addr_a = mem_q.r1[ADDR_W-1:0];

  // Read-first on both ports; the port A write is ordered last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    mem_dout <= dmem[addr_a];
    sw_dout  <= dmem[sw_addr];
    if (sw_we)       dmem[sw_addr] <= sw_din;
    if (mem_q.wmem_en) dmem[addr_a] <= mem_q.r2;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: abstract ALU/pipeline/memory model checked every negedge, plus literal spot checks.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] ex_r1 = '0, ex_r2 = '0;
  logic [3:0]  ex_opcode = '0;
  logic        ex_wreg_en = 1'b0, ex_wmem_en = 1'b0;
  logic [4:0]  ex_wreg = '0;
  logic [63:0] ex_z;
  logic        ex_carry, ex_overflow;
  logic        mem_wreg_en, mem_wmem_en;
  logic [4:0]  mem_wreg;
  logic [63:0] mem_z, mem_r1, mem_r2, mem_dout;
  logic [7:0]  sw_addr = '0;
  logic [63:0] sw_din = '0;
  logic        sw_we = 1'b0;
  logic [63:0] sw_dout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_opcode(ex_opcode),
    .ex_wreg_en(ex_wreg_en), .ex_wmem_en(ex_wmem_en), .ex_wreg(ex_wreg),
    .ex_z(ex_z), .ex_carry(ex_carry), .ex_overflow(ex_overflow),
    .mem_wreg_en(mem_wreg_en), .mem_wmem_en(mem_wmem_en), .mem_wreg(mem_wreg),
    .mem_z(mem_z), .mem_r1(mem_r1), .mem_r2(mem_r2), .mem_dout(mem_dout),
    .sw_addr(sw_addr), .sw_din(sw_din), .sw_we(sw_we), .sw_dout(sw_dout)
  );

  // Reference ALU from arithmetic definitions: returns {carry, overflow, z}.
  function automatic logic [65:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] u;
    logic signed [64:0] s;
    logic [63:0] z, ones;
    logic c, v;
    int sh;
    sh = int'(b[5:0]);
    ones = '1;
    z = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: begin
        u = {1'b0, a} + {1'b0, b};
        z = u[63:0]; c = u[64];
        s = $signed({a[63], a}) + $signed({b[63], b});
        v = s[64] ^ s[63];
      end
      4'b1000: begin
        z = a - b; c = (a >= b);
        s = $signed({a[63], a}) - $signed({b[63], b});
        v = s[64] ^ s[63];
      end
      4'b0001: z = a << sh;
      4'b0010: z = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b0011: z = (a < b) ? 64'd1 : 64'd0;
      4'b0100: z = a ^ b;
      4'b0101: z = a >> sh;
      4'b1101: z = (a >> sh) | (a[63] ? ~(ones >> sh) : 64'd0);
      4'b0110: z = a | b;
      4'b0111: z = a & b;
      default: z = '0;
    endcase
    return {c, v, z};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model state: what the EX/MEM register and memory must hold.
  logic        exp_wreg_en = 1'b0, exp_wmem_en = 1'b0;
  logic [4:0]  exp_wreg = '0;
  logic [65:0] exp_alu = '0;
  logic [63:0] exp_r1 = '0, exp_r2 = '0;
  logic [63:0] mdl [256];
  bit          vld [256];
  logic [63:0] exp_dout = '0, exp_sw = '0;
  bit          exp_dout_vld = 1'b0, exp_sw_vld = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_wreg_en <= 1'b0; exp_wmem_en <= 1'b0; exp_wreg <= '0;
      exp_alu <= '0; exp_r1 <= '0; exp_r2 <= '0;
    end else begin
      exp_wreg_en <= ex_wreg_en; exp_wmem_en <= ex_wmem_en; exp_wreg <= ex_wreg;
      exp_alu <= alu_ref(ex_opcode, ex_r1, ex_r2);
      exp_r1 <= ex_r1; exp_r2 <= ex_r2;
    end
  end

  always @(posedge clk) begin
    exp_dout     <= mdl[exp_r1[7:0]];
    exp_dout_vld <= vld[exp_r1[7:0]];
    exp_sw       <= mdl[sw_addr];
    exp_sw_vld   <= vld[sw_addr];
    if (exp_wmem_en) begin
      mdl[exp_r1[7:0]] <= exp_r2;
      vld[exp_r1[7:0]] <= 1'b1;
    end
    if (sw_we && !(exp_wmem_en && sw_addr == exp_r1[7:0])) begin
      mdl[sw_addr] <= sw_din;
      vld[sw_addr] <= 1'b1;
    end
  end

  logic [65:0] cur;
  always @(negedge clk) begin
    cur = alu_ref(ex_opcode, ex_r1, ex_r2);
    chk("ex_z", ex_z, cur[63:0]);
    chk("ex_carry", {63'd0, ex_carry}, {63'd0, cur[65]});
    chk("ex_overflow", {63'd0, ex_overflow}, {63'd0, cur[64]});
    chk("mem_wreg_en", {63'd0, mem_wreg_en}, {63'd0, exp_wreg_en});
    chk("mem_wmem_en", {63'd0, mem_wmem_en}, {63'd0, exp_wmem_en});
    chk("mem_wreg", {59'd0, mem_wreg}, {59'd0, exp_wreg});
    chk("mem_z", mem_z, exp_alu[63:0]);
    chk("mem_r1", mem_r1, exp_r1);
    chk("mem_r2", mem_r2, exp_r2);
    if (exp_dout_vld) chk("mem_dout", mem_dout, exp_dout);
    if (exp_sw_vld)   chk("sw_dout", sw_dout, exp_sw);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic wen, input logic men, input logic [4:0] wr);
    ex_opcode = op; ex_r1 = a; ex_r2 = b;
    ex_wreg_en = wen; ex_wmem_en = men; ex_wreg = wr;
  endtask

  logic [63:0] sa [3];
  logic [63:0] sb [3];

  initial begin
    sa[0] = 64'hF0F0_1234_8000_0001; sb[0] = 64'h0000_0000_0000_0025;
    sa[1] = 64'h8000_0000_0000_0000; sb[1] = 64'h8000_0000_0000_0000;
    sa[2] = 64'h0000_0000_0000_0003; sb[2] = 64'hFFFF_FFFF_FFFF_FFFF;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_z", mem_z, 64'd0);
    chk("reset_mem_wreg_en", {63'd0, mem_wreg_en}, 64'd0);
    reset = 1'b0;

    set_ex(4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 5'd7);
    #1;
    chk("add_ovf_z", ex_z, 64'h8000_0000_0000_0000);
    chk("add_ovf_v", {63'd0, ex_overflow}, 64'd1);
    chk("add_ovf_c", {63'd0, ex_carry}, 64'd0);
    tick();
    chk("pipe_wreg", {59'd0, mem_wreg}, 64'd7);
    chk("pipe_z", mem_z, 64'h8000_0000_0000_0000);

    set_ex(4'b1000, 64'd5, 64'd5, 1'b0, 1'b0, 5'd1);
    #1;
    chk("sub_eq_z", ex_z, 64'd0);
    chk("sub_eq_c", {63'd0, ex_carry}, 64'd1);
    tick();

    set_ex(4'b1101, 64'h8000_0000_0000_0000, 64'd63, 1'b1, 1'b0, 5'd2);
    #1; chk("sra63", ex_z, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    set_ex(4'b0101, 64'h8000_0000_0000_0000, 64'd63, 1'b1, 1'b0, 5'd3);
    #1; chk("srl63", ex_z, 64'd1);
    tick();
    set_ex(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 5'd4);
    #1; chk("slt", ex_z, 64'd1);
    tick();
    set_ex(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 5'd5);
    #1; chk("sltu", ex_z, 64'd0);
    tick();
    set_ex(4'b1010, 64'd5, 64'd3, 1'b1, 1'b0, 5'd6);
    #1;
    chk("op1010_z", ex_z, 64'd0);
    chk("op1010_flags", {62'd0, ex_carry, ex_overflow}, 64'd0);
    tick();

    for (int p = 0; p < 3; p++) begin
      for (int op = 0; op < 16; op++) begin
        set_ex(op[3:0], sa[p], sb[p], op[0], 1'b0, op[4:0]);
        tick();
      end
    end

    // Port B load, then pipeline read through a wrapped address.
    set_ex(4'b0000, 64'd0, 64'd0, 1'b0, 1'b0, 5'd0);
    sw_addr = 8'h03; sw_din = 64'hDEAD_BEEF_0000_0001; sw_we = 1'b1;
    tick();
    sw_we = 1'b0;
    set_ex(4'b0000, 64'h103, 64'd0, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    chk("wrap_read", mem_dout, 64'hDEAD_BEEF_0000_0001);

    // Pipeline store, inspected through port B.
    set_ex(4'b0000, 64'h10, 64'h55, 1'b0, 1'b1, 5'd0);
    tick();
    ex_wmem_en = 1'b0;
    tick();
    sw_addr = 8'h10;
    tick();
    chk("store_sw_read", sw_dout, 64'h55);

    // Same-address collision.
    set_ex(4'b0000, 64'h20, 64'hAAAA, 1'b0, 1'b1, 5'd0);
    tick();
    ex_wmem_en = 1'b0;
    sw_addr = 8'h20; sw_din = 64'hBBBB; sw_we = 1'b1;
    tick();
    sw_we = 1'b0;
    tick();
    chk("collide_sw", sw_dout, 64'hAAAA);
    chk("collide_a", mem_dout, 64'hAAAA);

    // Read-first on port B.
    sw_addr = 8'h03; sw_din = 64'h1234; sw_we = 1'b1;
    tick();
    sw_we = 1'b0;
    chk("read_first", sw_dout, 64'hDEAD_BEEF_0000_0001);
    tick();
    chk("after_write", sw_dout, 64'h1234);

    // Reset mid-stream.
    set_ex(4'b0000, 64'h40, 64'h99, 1'b1, 1'b1, 5'd9);
    tick();
    chk("pre_reset_wmem", {63'd0, mem_wmem_en}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_wreg_en", {63'd0, mem_wreg_en}, 64'd0);
    chk("async_wmem_en", {63'd0, mem_wmem_en}, 64'd0);
    chk("async_z", mem_z, 64'd0);
    set_ex(4'b0000, 64'h20, 64'd0, 1'b0, 1'b0, 5'd0);
    sw_addr = 8'h03;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("persist_b", sw_dout, 64'h1234);
    chk("persist_a", mem_dout, 64'hAAAA);
    tick();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

endmodule
